lmfc_tracker: RTL and testbench

Parametrised LMFC generator for JESD204B Subclass 1 receive paths. It aligns a multiframe beat counter to SYSREF and supports runtime multiframe length and SYSREF phase offset. It has two alignment modes: one-shot and continuous. After alignment it monitors every subsequent SYSREF for phase errors. It sits beside the lane aligners and feeds LMFC-boundary timing to elastic-buffer release and SYNC~ logic.

---
 rtl/lmfc_pkg.sv | 24 ++
 rtl/lmfc_sysref_capture.sv | 27 ++
 rtl/lmfc_tracker.sv | 107 ++++++++++
 tb/tb_lmfc_tracker.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmfc_pkg.sv
// Shared types and helpers for the LMFC tracker: alignment mode encoding,
// default multiframe size and modular subtraction for phase error reporting.
package lmfc_pkg;

    typedef enum logic {
        ONESHOT    = 1'b0,
        CONTINUOUS = 1'b1
    } lmfc_mode_e;

    localparam int MAX_BEATS_DEF = 256;

    // Wide enough for any legal multiframe length (up to 256 beats).
    localparam int LMFC_W = 9;

    // (a - b) mod m, for a and b already reduced below m.
    function automatic logic [LMFC_W-1:0] mod_sub(
        input logic [LMFC_W-1:0] a,
        input logic [LMFC_W-1:0] b,
        input logic [LMFC_W-1:0] m
    );
        return (a >= b) ? (a - b) : (a + m - b);
    endfunction

endpackage

// File: rtl/lmfc_sysref_capture.sv
// SYSREF capture: multi-flop synchroniser followed by a registered rising-edge
// detector. A level held high yields exactly one single-cycle pulse.
module lmfc_sysref_capture #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sysref,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sysref};
            prev_q <= sync_q[SYNC_STAGES-1];
            pulse  <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/lmfc_tracker.sv
// JESD204B Subclass 1 LMFC generator: aligns a multiframe beat counter to
// SYSREF (one-shot or continuous) and flags SYSREF phase errors afterwards.
module lmfc_tracker
    import lmfc_pkg::*;
#(
    parameter int PARALLEL_OCTETS  = 4,
    parameter int MAX_BEATS_PER_MF = MAX_BEATS_DEF,
    parameter int CNT_W            = $clog2(MAX_BEATS_PER_MF),
    parameter int SYNC_STAGES      = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sysref_i,
    input  logic             mode_i,
    input  logic             rearm_i,
    input  logic [CNT_W:0]   beats_per_mf_i,
    input  logic [CNT_W-1:0] sysref_offset_i,
    input  logic             err_clr_i,
    output logic             lmfc_pulse_o,
    output logic [CNT_W-1:0] lmfc_counter_o,
    output logic             lmfc_valid_o,
    output logic             misalign_o,
    output logic             cfg_err_o,
    output logic [CNT_W-1:0] phase_err_o,
    output logic [7:0]       sysref_cnt_o
);

    if (PARALLEL_OCTETS < 1 || MAX_BEATS_PER_MF < 2 || MAX_BEATS_PER_MF > 256 ||
        (MAX_BEATS_PER_MF & (MAX_BEATS_PER_MF - 1)) != 0 ||
        SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_cfg
        $error("lmfc_tracker: unsupported parameter set");
    end

    localparam logic [CNT_W:0]   MAX_BEATS = (CNT_W+1)'(MAX_BEATS_PER_MF);
    localparam logic [CNT_W:0]   ONE_B     = (CNT_W+1)'(1);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic             sysref_pulse;
    logic [CNT_W-1:0] cnt_q, next_cnt, eff_off, phase_err_q;
    logic [CNT_W:0]   beats_q, beats_new;
    logic             wrap, beats_bad, off_bad, armed, align, check, mismatch, cfg_hit;
    logic             armed_q, valid_q, misalign_q, cfg_err_q;
    logic [7:0]       sr_cnt_q;

    lmfc_sysref_capture #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_capture (
        .clk    (clk_i),
        .rst    (rst_i),
        .sysref (sysref_i),
        .pulse  (sysref_pulse)
    );

    always_comb begin
        wrap      = ({1'b0, cnt_q} == (beats_q - ONE_B));
        next_cnt  = wrap ? '0 : (cnt_q + ONE_C);
        beats_bad = (beats_per_mf_i == '0) || (beats_per_mf_i > MAX_BEATS);
        beats_new = beats_bad ? MAX_BEATS : beats_per_mf_i;
        off_bad   = ({1'b0, sysref_offset_i} >= beats_new);
        eff_off   = off_bad ? '0 : sysref_offset_i;
        // A rearm arriving with the pulse counts as armed for that pulse.
        armed     = armed_q | rearm_i;
        align     = sysref_pulse & (armed | (lmfc_mode_e'(mode_i) == CONTINUOUS));
        check     = sysref_pulse & valid_q & ~armed;
        mismatch  = check & (next_cnt != eff_off);
        cfg_hit   = (align & (beats_bad | off_bad)) | (~align & wrap & beats_bad);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            beats_q     <= MAX_BEATS;
            armed_q     <= 1'b1;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            phase_err_q <= '0;
            sr_cnt_q    <= '0;
        end else begin
            // Length is only picked up at a boundary so no multiframe is cut short.
            if (align) begin
                cnt_q   <= eff_off;
                beats_q <= beats_new;
                valid_q <= 1'b1;
            end else begin
                cnt_q <= next_cnt;
                if (wrap) beats_q <= beats_new;
            end
            armed_q <= armed & ~align;
            if (mismatch)
                phase_err_q <= CNT_W'(mod_sub(LMFC_W'(eff_off), LMFC_W'(next_cnt), LMFC_W'(beats_q)));
            misalign_q <= mismatch | (misalign_q & ~err_clr_i);
            cfg_err_q  <= cfg_hit | (cfg_err_q & ~err_clr_i);
            if (sysref_pulse && sr_cnt_q != 8'hFF)
                sr_cnt_q <= sr_cnt_q + 8'd1;
        end
    end

    assign lmfc_counter_o = cnt_q;
    assign lmfc_valid_o   = valid_q;
    assign lmfc_pulse_o   = valid_q & (cnt_q == '0);
    assign misalign_o     = misalign_q;
    assign cfg_err_o      = cfg_err_q;
    assign phase_err_o    = phase_err_q;
    assign sysref_cnt_o   = sr_cnt_q;

endmodule

// File: tb/tb_lmfc_tracker.sv
// Scoreboard bench for lmfc_tracker: each stimulus step queues the outputs it
// must produce at a given cycle; a negedge monitor pops and compares them.
module tb_lmfc_tracker;

    localparam int CNT_W = 8;
    localparam int S_CNT = 0, S_VLD = 1, S_PUL = 2, S_MIS = 3, S_CFG = 4, S_PHE = 5, S_SRC = 6;

    logic             clk_i = 1'b0;
    logic             rst_i, sysref_i, mode_i, rearm_i, err_clr_i;
    logic [CNT_W:0]   beats_per_mf_i;
    logic [CNT_W-1:0] sysref_offset_i;
    logic             lmfc_pulse_o, lmfc_valid_o, misalign_o, cfg_err_o;
    logic [CNT_W-1:0] lmfc_counter_o, phase_err_o;
    logic [7:0]       sysref_cnt_o;

    lmfc_tracker dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .sysref_i        (sysref_i),
        .mode_i          (mode_i),
        .rearm_i         (rearm_i),
        .beats_per_mf_i  (beats_per_mf_i),
        .sysref_offset_i (sysref_offset_i),
        .err_clr_i       (err_clr_i),
        .lmfc_pulse_o    (lmfc_pulse_o),
        .lmfc_counter_o  (lmfc_counter_o),
        .lmfc_valid_o    (lmfc_valid_o),
        .misalign_o      (misalign_o),
        .cfg_err_o       (cfg_err_o),
        .phase_err_o     (phase_err_o),
        .sysref_cnt_o    (sysref_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int    at;
        string tag;
        int    sel;
        int    val;
    } sb_t;
    sb_t sb[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int dut_val(input int sel);
        case (sel)
            S_CNT:   return int'(lmfc_counter_o);
            S_VLD:   return int'(lmfc_valid_o);
            S_PUL:   return int'(lmfc_pulse_o);
            S_MIS:   return int'(misalign_o);
            S_CFG:   return int'(cfg_err_o);
            S_PHE:   return int'(phase_err_o);
            default: return int'(sysref_cnt_o);
        endcase
    endfunction

    task automatic push(input int at, input string tag, input int sel, input int val);
        sb_t e;
        e.at = at; e.tag = tag; e.sel = sel; e.val = val;
        sb.push_back(e);
    endtask

    always @(negedge clk_i) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                chk(sb[i].tag, dut_val(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_sr(input int hi);
        sysref_i = 1'b1;
        repeat (hi) tick();
        sysref_i = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
    endtask

    task automatic pulse_rearm();
        rearm_i = 1'b1;
        tick();
        rearm_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m, a, s;
        rst_i = 1'b1; sysref_i = 1'b0; mode_i = 1'b0; rearm_i = 1'b0; err_clr_i = 1'b0;
        beats_per_mf_i = 9'd16; sysref_offset_i = 8'd0;
        repeat (3) tick();
        push(cyc, "rst_cnt", S_CNT, 0); push(cyc, "rst_vld", S_VLD, 0);
        push(cyc, "rst_pul", S_PUL, 0); push(cyc, "rst_mis", S_MIS, 0);
        push(cyc, "rst_cfg", S_CFG, 0); push(cyc, "rst_phe", S_PHE, 0);
        push(cyc, "rst_src", S_SRC, 0);
        tick();
        rst_i = 1'b0;

        // Basic one-shot alignment, beats 16, offset 0
        m = cyc + 4; wait_until(m); a = m + 4;
        push(a - 1, "pre_vld", S_VLD, 0);
        push(a, "aln_cnt", S_CNT, 0); push(a, "aln_vld", S_VLD, 1);
        push(a, "aln_pul", S_PUL, 1); push(a, "aln_src", S_SRC, 1);
        push(a + 1, "aln_cnt1", S_CNT, 1); push(a + 1, "aln_pul0", S_PUL, 0);
        push(a + 15, "aln_cnt15", S_CNT, 15); push(a + 16, "mf2_pul", S_PUL, 1);
        pulse_sr(4);

        // Periodic aligned SYSREF every 32 cycles
        for (int k = 1; k <= 3; k++) begin
            wait_until(m + 32 * k);
            push(a + 32 * k, $sformatf("per%0d_cnt", k), S_CNT, 0);
            push(a + 32 * k, $sformatf("per%0d_mis", k), S_MIS, 0);
            push(a + 32 * k, $sformatf("per%0d_src", k), S_SRC, 1 + k);
            pulse_sr(4);
        end

        // One-shot: SYSREF 3 beats late is flagged but does not move the counter
        wait_until(m + 131);
        push(m + 134, "os_mis0", S_MIS, 0);
        push(m + 135, "os_mis", S_MIS, 1); push(m + 135, "os_phe", S_PHE, 13);
        push(m + 135, "os_cnt", S_CNT, 3); push(m + 136, "os_cnt1", S_CNT, 4);
        pulse_sr(4);

        wait_until(m + 150);
        push(m + 151, "clr_mis", S_MIS, 0); push(m + 151, "clr_phe", S_PHE, 13);
        pulse_clr();
        mode_i = 1'b1;

        // Continuous: late SYSREF flags and realigns
        wait_until(m + 163);
        push(m + 167, "ct_cnt", S_CNT, 0); push(m + 167, "ct_mis", S_MIS, 1);
        push(m + 167, "ct_phe", S_PHE, 13); push(m + 168, "ct_cnt1", S_CNT, 1);
        pulse_sr(4);

        wait_until(m + 175); mode_i = 1'b0;
        wait_until(m + 176);
        push(m + 177, "clr2_mis", S_MIS, 0);
        pulse_clr();

        // Rearm then SYSREF with offset 5: realign without a phase check
        wait_until(m + 180);
        sysref_offset_i = 8'd5;
        pulse_rearm();
        wait_until(m + 190);
        push(m + 194, "rea_cnt", S_CNT, 5); push(m + 194, "rea_mis", S_MIS, 0);
        push(m + 195, "rea_cnt1", S_CNT, 6);
        pulse_sr(4);

        // Rearm in the same cycle as the pulse
        wait_until(m + 215); sysref_offset_i = 8'd9;
        wait_until(m + 220);
        push(m + 224, "same_cnt", S_CNT, 9); push(m + 224, "same_mis", S_MIS, 0);
        pulse_sr(3);
        pulse_rearm();

        // Armed flag must now be clear: next late SYSREF is only flagged
        wait_until(m + 250);
        push(m + 254, "disarm_cnt", S_CNT, 7); push(m + 254, "disarm_mis", S_MIS, 1);
        push(m + 254, "disarm_phe", S_PHE, 2);
        pulse_sr(4);

        // Offset beyond multiframe loads 0 and flags a config error
        wait_until(m + 260);
        push(m + 261, "clr3_mis", S_MIS, 0); push(m + 261, "clr3_cfg", S_CFG, 0);
        pulse_clr();
        sysref_offset_i = 8'd20;
        wait_until(m + 265); pulse_rearm();
        wait_until(m + 270);
        push(m + 274, "off_cnt", S_CNT, 0); push(m + 274, "off_cfg", S_CFG, 1);
        push(m + 274, "off_mis", S_MIS, 0);
        pulse_sr(4);

        // Clear coinciding with a new error: the error wins
        wait_until(m + 280);
        push(m + 281, "clr4_cfg", S_CFG, 0);
        pulse_clr();
        wait_until(m + 285); pulse_rearm();
        wait_until(m + 290);
        push(m + 294, "race_cfg", S_CFG, 1); push(m + 294, "race_cnt", S_CNT, 0);
        pulse_sr(3);
        pulse_clr();

        // Illegal beats 0: captured at the next wrap as 256
        wait_until(m + 300);
        push(m + 301, "clr5_cfg", S_CFG, 0);
        pulse_clr();
        sysref_offset_i = 8'd0;
        beats_per_mf_i = 9'd0;
        push(m + 309, "b0_cfg0", S_CFG, 0);
        push(m + 310, "b0_cfg", S_CFG, 1); push(m + 310, "b0_cnt", S_CNT, 0);
        push(m + 326, "b0_cnt16", S_CNT, 16);
        push(m + 565, "b0_cnt255", S_CNT, 255); push(m + 566, "b0_wrap", S_CNT, 0);

        // Mid-operation reset, then one-beat multiframe
        wait_until(m + 590); beats_per_mf_i = 9'd1;
        wait_until(m + 600);
        rst_i = 1'b1;
        push(m + 601, "mrst_cnt", S_CNT, 0); push(m + 601, "mrst_vld", S_VLD, 0);
        push(m + 601, "mrst_cfg", S_CFG, 0); push(m + 601, "mrst_mis", S_MIS, 0);
        push(m + 601, "mrst_src", S_SRC, 0); push(m + 601, "mrst_phe", S_PHE, 0);
        push(m + 601, "mrst_pul", S_PUL, 0);
        tick();
        rst_i = 1'b0;
        wait_until(m + 610);
        push(m + 613, "b1_vld0", S_VLD, 0);
        push(m + 614, "b1_cnt", S_CNT, 0); push(m + 614, "b1_vld", S_VLD, 1);
        push(m + 614, "b1_pul", S_PUL, 1); push(m + 614, "b1_src", S_SRC, 1);
        push(m + 615, "b1_cnt1", S_CNT, 0); push(m + 615, "b1_pul1", S_PUL, 1);
        push(m + 619, "b1_pul5", S_PUL, 1);
        pulse_sr(4);

        // SYSREF edge counter saturation (one edge already counted)
        s = m + 620;
        push(s + 4 * 252 + 4, "sat_254", S_SRC, 254);
        push(s + 4 * 253 + 4, "sat_255", S_SRC, 255);
        push(s + 4 * 299 + 8, "sat_hold", S_SRC, 255);
        for (int i = 0; i < 300; i++) begin
            wait_until(s + 4 * i);
            sysref_i = 1'b1;
            tick();
            sysref_i = 1'b0;
        end

        wait_until(s + 1220);
        chk("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
